// File: rtl/cfg_pkg.sv
// ============================================================================
// cfg_pkg : shared definitions for the serial configuration loader
// Revision: 1.0
// ============================================================================
`default_nettype none

package cfg_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_HUNT  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_CRC   = 2'd2;
    localparam state_t ST_CHECK = 2'd3;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;
    localparam logic [7:0] CRC_POLY          = 8'h07;
    localparam int         CRC_W             = 8;

    // One MSB-first step of the non-reflected CRC-8.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic b);
        return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? CRC_POLY : 8'h00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/crc8_serial.sv
// ============================================================================
// crc8_serial : bit-serial CRC-8 accumulator, clear has priority over enable
// Revision: 1.0
// ============================================================================
`default_nettype none

module crc8_serial
    import cfg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = 8'h00;
        end else if (en) begin
            crc_d = crc8_next(crc_q, bit_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

`default_nettype wire

// File: rtl/cfg_loader.sv
// ============================================================================
// cfg_loader : framed serial bitstream loader (sync, payload, CRC-8) that
//              commits logic-block configuration only on a CRC pass
// Revision: 1.0
// ============================================================================
`default_nettype none

module cfg_loader
    import cfg_pkg::*;
#(
    parameter int         CFG_SIZE   = 10,
    parameter int         NUM_BLOCKS = 4,
    parameter logic [7:0] SYNC_WORD  = SYNC_WORD_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         bs_valid,
    input  logic                         bs_data,
    output logic                         bs_ready,
    input  logic                         cfg_abort,
    output logic [CFG_SIZE*NUM_BLOCKS-1:0] cfg_out,
    output logic                         cfg_valid,
    output logic                         cfg_done,
    output logic                         cfg_err,
    output logic                         busy
);

    localparam int P     = CFG_SIZE * NUM_BLOCKS;
    localparam int CNT_W = $clog2(P + 1);

    localparam logic [CNT_W-1:0] LAST_PAYLOAD = CNT_W'(P - 1);
    localparam logic [CNT_W-1:0] LAST_CRC     = CNT_W'(CRC_W - 1);

    state_t           state_q, state_d;
    logic [7:0]       hunt_q, hunt_d;
    logic [P-1:0]     shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [P-1:0]     cfg_out_q, cfg_out_d;
    logic             cfg_valid_q, cfg_valid_d;
    logic             cfg_err_q, cfg_err_d;
    logic             cfg_done_q, cfg_done_d;

    logic             xfer;
    logic [7:0]       hunt_shift;
    logic             sync_hit;
    logic             crc_clr;
    logic             crc_en;
    logic [7:0]       crc;

    assign xfer       = bs_valid && bs_ready;
    assign hunt_shift = {hunt_q[6:0], bs_data};
    assign sync_hit   = (hunt_shift == SYNC_WORD);

    crc8_serial u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (bs_data),
        .crc    (crc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            hunt_q      <= 8'h00;
            shadow_q    <= '0;
            cnt_q       <= '0;
            cfg_out_q   <= '0;
            cfg_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            cfg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hunt_q      <= hunt_d;
            shadow_q    <= shadow_d;
            cnt_q       <= cnt_d;
            cfg_out_q   <= cfg_out_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_err_q   <= cfg_err_d;
            cfg_done_q  <= cfg_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cfg_abort) begin
            state_d = ST_HUNT;
        end else begin
            case (state_q)
                ST_HUNT:  if (xfer && sync_hit) state_d = ST_LOAD;
                ST_LOAD:  if (xfer && cnt_q == LAST_PAYLOAD) state_d = ST_CRC;
                ST_CRC:   if (xfer && cnt_q == LAST_CRC) state_d = ST_CHECK;
                ST_CHECK: state_d = ST_HUNT;
                default:  state_d = ST_HUNT;
            endcase
        end
    end

    // Abort drops the bit presented this cycle and leaves committed outputs alone.
    always_comb begin
        hunt_d      = hunt_q;
        shadow_d    = shadow_q;
        cnt_d       = cnt_q;
        cfg_out_d   = cfg_out_q;
        cfg_valid_d = cfg_valid_q;
        cfg_err_d   = cfg_err_q;
        cfg_done_d  = 1'b0;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;
        if (cfg_abort) begin
            hunt_d = 8'h00;
            cnt_d  = '0;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    if (xfer) begin
                        hunt_d = hunt_shift;
                        if (sync_hit) begin
                            cfg_err_d = 1'b0;
                            crc_clr   = 1'b1;
                            cnt_d     = '0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        shadow_d = {shadow_q[P-2:0], bs_data};
                        crc_en   = 1'b1;
                        cnt_d    = (cnt_q == LAST_PAYLOAD) ? '0 : cnt_q + CNT_W'(1);
                    end
                end
                ST_CRC: begin
                    if (xfer) begin
                        crc_en = 1'b1;
                        cnt_d  = (cnt_q == LAST_CRC) ? '0 : cnt_q + CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    hunt_d = 8'h00;
                    if (crc == 8'h00) begin
                        cfg_out_d   = shadow_q;
                        cfg_valid_d = 1'b1;
                        cfg_done_d  = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bs_ready  = (state_q != ST_CHECK);
        busy      = (state_q != ST_HUNT);
        cfg_out   = cfg_out_q;
        cfg_valid = cfg_valid_q;
        cfg_done  = cfg_done_q;
        cfg_err   = cfg_err_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_cfg_loader.sv
// ============================================================================
// tb_cfg_loader : directed self-checking bench with a commit scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cfg_loader;

    localparam int CFG_SIZE   = 10;
    localparam int NUM_BLOCKS = 2;
    localparam int P          = CFG_SIZE * NUM_BLOCKS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         bs_valid = 1'b0;
    logic         bs_data = 1'b0;
    logic         bs_ready;
    logic         cfg_abort = 1'b0;
    logic [P-1:0] cfg_out;
    logic         cfg_valid;
    logic         cfg_done;
    logic         cfg_err;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int rdy_low_cnt = 0;
    logic [P-1:0] sb[$];

    cfg_loader #(
        .CFG_SIZE   (CFG_SIZE),
        .NUM_BLOCKS (NUM_BLOCKS),
        .SYNC_WORD  (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bs_valid  (bs_valid),
        .bs_data   (bs_data),
        .bs_ready  (bs_ready),
        .cfg_abort (cfg_abort),
        .cfg_out   (cfg_out),
        .cfg_valid (cfg_valid),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] crc_of(input logic [P-1:0] p);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = P - 1; i >= 0; i--) begin
            fb = c[7] ^ p[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (!bs_ready) rdy_low_cnt++;
        if (cfg_done) begin
            done_cnt++;
            if (sb.size() == 0) check("spurious_done", {31'd0, cfg_done}, 32'd0);
            else check("commit_data", {12'd0, cfg_out}, {12'd0, sb.pop_front()});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit rnd);
        int waited;
        if (rnd) begin
            for (int g = 0; g < 4; g++) begin
                if ($urandom_range(0, 1) == 0) break;
                tick();
            end
        end
        bs_valid = 1'b1;
        bs_data  = b;
        waited   = 0;
        while (!bs_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (waited >= 20) check("ready_timeout", {31'd0, bs_ready}, 32'd1);
        tick();
        bs_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        for (int i = 7; i >= 0; i--) send_bit(b[i], rnd);
    endtask

    task automatic send_payload(input logic [P-1:0] p, input bit rnd);
        for (int i = P - 1; i >= 0; i--) send_bit(p[i], rnd);
    endtask

    // Expected commits are queued before the frame is driven.
    task automatic send_frame(input logic [P-1:0] p, input bit flip, input bit rnd);
        if (!flip) begin
            sb.push_back(p);
            exp_done++;
        end
        send_byte(8'hA5, rnd);
        send_payload(p, rnd);
        send_byte(crc_of(p) ^ {7'd0, flip}, rnd);
    endtask

    initial begin
        int rdy_before;
        int done_before;

        // Reset values
        repeat (3) tick();
        check("rst_cfg_out", {12'd0, cfg_out}, 32'd0);
        check("rst_cfg_valid", {31'd0, cfg_valid}, 32'd0);
        check("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
        check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_bs_ready", {31'd0, bs_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // 1: good frame and commit latency
        send_frame(20'hF00FF, 1'b0, 1'b0);
        check("t1_ready_low_check", {31'd0, bs_ready}, 32'd0);
        check("t1_no_done_yet", {31'd0, cfg_done}, 32'd0);
        check("t1_busy_check", {31'd0, busy}, 32'd1);
        tick();
        check("t1_done_pulse", {31'd0, cfg_done}, 32'd1);
        check("t1_cfg_out", {12'd0, cfg_out}, 32'h000F00FF);
        check("t1_cfg_valid", {31'd0, cfg_valid}, 32'd1);
        check("t1_cfg_err", {31'd0, cfg_err}, 32'd0);
        check("t1_ready_back", {31'd0, bs_ready}, 32'd1);
        check("t1_busy_idle", {31'd0, busy}, 32'd0);
        tick();
        check("t1_done_one_cycle", {31'd0, cfg_done}, 32'd0);
        check("t1_done_count", done_cnt, 32'd1);

        // 2: bad CRC, then recovery
        send_frame(20'hF00FF, 1'b1, 1'b0);
        tick();
        tick();
        check("t2_err_set", {31'd0, cfg_err}, 32'd1);
        check("t2_out_kept", {12'd0, cfg_out}, 32'h000F00FF);
        check("t2_no_done", done_cnt, 32'd1);
        sb.push_back(20'h3C5A1);
        exp_done++;
        send_byte(8'hA5, 1'b0);
        check("t2_err_clear_at_sync", {31'd0, cfg_err}, 32'd0);
        check("t2_busy_at_sync", {31'd0, busy}, 32'd1);
        send_payload(20'h3C5A1, 1'b0);
        send_byte(crc_of(20'h3C5A1), 1'b0);
        tick();
        tick();
        check("t2_out_updated", {12'd0, cfg_out}, 32'h0003C5A1);

        // 3: leading noise, then a sync at bit offset 3
        send_byte(8'h0F, 1'b0);
        send_byte(8'h0F, 1'b0);
        check("t3_no_false_sync", {31'd0, busy}, 32'd0);
        send_frame(20'hABCDE, 1'b0, 1'b0);
        tick();
        tick();
        check("t3_out", {12'd0, cfg_out}, 32'h000ABCDE);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
        sb.push_back(20'h55AA3);
        exp_done++;
        send_byte(8'hA5, 1'b0);
        check("t3_lock_offset3", {31'd0, busy}, 32'd1);
        send_payload(20'h55AA3, 1'b0);
        send_byte(crc_of(20'h55AA3), 1'b0);
        tick();
        tick();
        check("t3_offset_out", {12'd0, cfg_out}, 32'h00055AA3);

        // 4: throttled bs_valid
        rdy_before = rdy_low_cnt;
        send_frame(20'h9E37B, 1'b0, 1'b1);
        tick();
        tick();
        check("t4_out", {12'd0, cfg_out}, 32'h0009E37B);
        check("t4_ready_low_cycles", rdy_low_cnt - rdy_before, 32'd1);

        // 5: abort mid-payload, then abort during CHECK
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 12; i++) send_bit(1'b1, 1'b0);
        bs_valid  = 1'b1;
        bs_data   = 1'b1;
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        bs_valid  = 1'b0;
        check("t5_abort_idle", {31'd0, busy}, 32'd0);
        check("t5_abort_out_kept", {12'd0, cfg_out}, 32'h0009E37B);
        send_frame(20'h0A0F5, 1'b0, 1'b0);
        tick();
        tick();
        check("t5_second_commit", {12'd0, cfg_out}, 32'h000A0F5);
        done_before = done_cnt;
        send_byte(8'hA5, 1'b0);
        send_payload(20'h11111, 1'b0);
        send_byte(crc_of(20'h11111), 1'b0);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check("t5_check_abort_busy", {31'd0, busy}, 32'd0);
        check("t5_check_abort_done", {31'd0, cfg_done}, 32'd0);
        check("t5_check_abort_err", {31'd0, cfg_err}, 32'd0);
        tick();
        check("t5_check_abort_out", {12'd0, cfg_out}, 32'h000A0F5);
        check("t5_check_abort_cnt", done_cnt - done_before, 32'd0);

        // 6: asynchronous reset mid-payload
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_out_cleared", {12'd0, cfg_out}, 32'd0);
        check("t6_valid_cleared", {31'd0, cfg_valid}, 32'd0);
        check("t6_busy_cleared", {31'd0, busy}, 32'd0);
        check("t6_ready_high", {31'd0, bs_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        check("sb_empty", sb.size(), 32'd0);
        check("done_total", done_cnt, exp_done);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
